// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with output FIFO; DECODE_RV32M_EN makes funct7=0000001 R-type legal
module decode_stage #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WORD_WIDTH-1:0] instr_i,
    input  logic [WORD_WIDTH-1:0] pc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [2:0]            op_type_o,
    output logic [WORD_WIDTH-1:0] imm_o,
    output logic [4:0]            rs1_o,
    output logic [4:0]            rs2_o,
    output logic [4:0]            rd_o,
    output logic [2:0]            funct3_o,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic                  illegal_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    if (WORD_WIDTH != 32) begin : g_bad_width
        $error("decode_stage: WORD_WIDTH must be 32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("decode_stage: DEPTH must be a power of two >= 2");
    end

    localparam logic [2:0] T_R   = 3'b000;
    localparam logic [2:0] T_I   = 3'b001;
    localparam logic [2:0] T_S   = 3'b010;
    localparam logic [2:0] T_SB  = 3'b011;
    localparam logic [2:0] T_U   = 3'b100;
    localparam logic [2:0] T_UJ  = 3'b101;
    localparam logic [2:0] T_BAD = 3'b111;

    typedef struct packed {
        logic [2:0]            op_type;
        logic [WORD_WIDTH-1:0] imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [2:0]            funct3;
        logic [WORD_WIDTH-1:0] pc;
        logic                  illegal;
    } entry_t;

    entry_t                decoded;
    logic [2:0]            type_raw;
    logic [WORD_WIDTH-1:0] imm_raw;
    logic                  illegal;
    logic [6:0]            opcode;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic                  funct7_ok;

    assign opcode = instr_i[6:0];
    assign funct7 = instr_i[31:25];
    assign funct3 = instr_i[14:12];

    always_comb begin
        type_raw = T_BAD;
        case (opcode)
            7'b0110011: type_raw = T_R;
            7'b1110011, 7'b0010011, 7'b0001111,
            7'b0000011, 7'b1100111: type_raw = T_I;
            7'b0100011: type_raw = T_S;
            7'b1100011: type_raw = T_SB;
            7'b0010111, 7'b0110111: type_raw = T_U;
            7'b1101111: type_raw = T_UJ;
            default:    type_raw = T_BAD;
        endcase
    end

    always_comb begin
        imm_raw = '0;
        case (type_raw)
            T_I:  imm_raw = {{20{instr_i[31]}}, instr_i[31:20]};
            T_S:  imm_raw = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            T_SB: imm_raw = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
            T_U:  imm_raw = {instr_i[31:12], 12'b0};
            T_UJ: imm_raw = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
            default: imm_raw = '0;
        endcase
    end

    // Base ALU ops use funct7 0000000; 0100000 only encodes SUB and SRA.
    always_comb begin
        funct7_ok = 1'b0;
        if (funct7 == 7'b0000000) begin
            funct7_ok = 1'b1;
        end else if (funct7 == 7'b0100000) begin
            funct7_ok = (funct3 == 3'b000) || (funct3 == 3'b101);
        end
`ifdef DECODE_RV32M_EN
        else if (funct7 == 7'b0000001) begin
            funct7_ok = 1'b1;
        end
`endif
    end

    always_comb begin
        illegal = 1'b0;
        if (type_raw == T_BAD)                                       illegal = 1'b1;
        if (instr_i[1:0] != 2'b11)                                   illegal = 1'b1;
        if (type_raw == T_R && !funct7_ok)                           illegal = 1'b1;
        if (opcode == 7'b1100111 && funct3 != 3'b000)                illegal = 1'b1;
        if (opcode == 7'b1100011 && funct3[2:1] == 2'b01)            illegal = 1'b1;
    end

    always_comb begin
        decoded         = '0;
        decoded.op_type = illegal ? T_BAD : type_raw;
        decoded.imm     = illegal ? '0 : imm_raw;
        decoded.rs1     = instr_i[19:15];
        decoded.rs2     = instr_i[24:20];
        decoded.rd      = instr_i[11:7];
        decoded.funct3  = funct3;
        decoded.pc      = pc_i;
        decoded.illegal = illegal;
    end

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    entry_t           head;

    assign in_ready_o  = rst_n && (count != FULL) && !flush_i;
    assign out_valid_o = (count != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= decoded;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Empty FIFO presents zeros rather than whatever stale entry the read pointer addresses.
    assign head      = out_valid_o ? mem[rd_ptr] : '0;
    assign op_type_o = head.op_type;
    assign imm_o     = head.imm;
    assign rs1_o     = head.rs1;
    assign rs2_o     = head.rs2;
    assign rd_o      = head.rd;
    assign funct3_o  = head.funct3;
    assign pc_o      = head.pc;
    assign illegal_o = head.illegal;

endmodule
